// File: rtl/fetch_queue.sv
// fetch_queue: dual-issue in-order instruction fetch queue that stalls fetch when it cannot take a full pair
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [1:0]             in_valid,
  input  logic [2*WIDTH-1:0]     in_pc,
  input  logic [2*WIDTH-1:0]     in_instr,
  output logic                   stall_F,
  output logic [1:0]             out_valid,
  output logic [2*WIDTH-1:0]     out_pc,
  output logic [2*WIDTH-1:0]     out_instr,
  input  logic [1:0]             out_take,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] pc_q [DEPTH];
  logic [WIDTH-1:0] instr_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, head1, tail1;
  logic [AW:0] count_q, count_d;
  logic [1:0] np, pp;
  always_comb begin
    stall_F = (DEPTH - int'(count_q)) < 2;
    out_valid = {count_q > (AW+1)'(1), count_q != '0};
    head1 = head_q + AW'(1);
    tail1 = tail_q + AW'(1);
    np = stall_F ? 2'd0 : in_valid == 2'b11 ? 2'd2 : {1'b0, in_valid == 2'b01};
    pp = {1'b0, out_take[0] & out_valid[0]} + {1'b0, &out_take & out_valid[1]};
    out_pc = {out_valid[1] ? pc_q[head1] : '0, out_valid[0] ? pc_q[head_q] : '0};
    out_instr = {out_valid[1] ? instr_q[head1] : '0, out_valid[0] ? instr_q[head_q] : '0};
    head_d = flush ? '0 : head_q + AW'(pp);
    tail_d = flush ? '0 : tail_q + AW'(np);
    count_d = flush ? '0 : count_q + (AW+1)'(np) - (AW+1)'(pp);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!flush && np != 2'd0) begin
      pc_q[tail_q] <= in_pc[WIDTH-1:0];
      instr_q[tail_q] <= in_instr[WIDTH-1:0];
    end
    if (!flush && np == 2'd2) begin
      pc_q[tail1] <= in_pc[2*WIDTH-1:WIDTH];
      instr_q[tail1] <= in_instr[2*WIDTH-1:WIDTH];
    end
  end
  assign count = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed tests for fetch_queue with hand-computed expectations and an order scoreboard
module tb_fetch_queue;
  logic clk = 0, rst = 0, flush = 0;
  logic [1:0] in_valid = 0, out_take = 0;
  logic [63:0] in_pc = 0, in_instr = 0;
  logic stall_F;
  logic [1:0] out_valid;
  logic [63:0] out_pc, out_instr;
  logic [3:0] count;
  int errs = 0, checks = 0;
  fetch_queue #(.WIDTH(32), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr(in_instr), .stall_F(stall_F), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .out_take(out_take), .count(count)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ins(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1, input logic [1:0] t);
    in_valid = v;
    in_pc = {p1, p0};
    in_instr = {ins(p1), ins(p0)};
    out_take = t;
  endtask
  task automatic test_reset();
    rst = 0;
    drive(2'b11, 32'h40, 32'h44, 2'b00);
    repeat (2) step();
    checks++; if (count !== 4'd0) begin errs++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 2'b00) begin errs++; $display("FAIL reset_valid got=%b exp=00", out_valid); end
    checks++; if (stall_F !== 1'b0) begin errs++; $display("FAIL reset_stall got=%b exp=0", stall_F); end
    drive(2'b00, 0, 0, 2'b00);
    rst = 1;
    #1;
    checks++; if (out_pc !== 64'd0) begin errs++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    checks++; if (out_instr !== 64'd0) begin errs++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
  endtask
  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 32'(8 * k), 32'(8 * k + 4), 2'b00);
      step();
      checks++; if (count !== 4'(2 * k + 2)) begin errs++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", k, count, 2 * k + 2); end
      checks++; if (stall_F !== (k == 3)) begin errs++; $display("FAIL fill_stall[%0d] got=%b exp=%b", k, stall_F, k == 3); end
    end
    drive(2'b11, 32'h20, 32'h24, 2'b00);
    step();
    checks++; if (count !== 4'd8) begin errs++; $display("FAIL fill_ignored_count got=%0d exp=8", count); end
    checks++; if (stall_F !== 1'b1) begin errs++; $display("FAIL fill_ignored_stall got=%b exp=1", stall_F); end
  endtask
  task automatic test_drain();
    for (int k = 0; k < 4; k++) begin
      drive(2'b00, 0, 0, 2'b11);
      checks++; if (out_valid !== 2'b11) begin errs++; $display("FAIL drain_valid[%0d] got=%b exp=11", k, out_valid); end
      checks++; if (out_pc !== {32'(8 * k + 4), 32'(8 * k)}) begin errs++; $display("FAIL drain_pc[%0d] got=%h exp=%h", k, out_pc, {32'(8 * k + 4), 32'(8 * k)}); end
      checks++; if (out_instr !== {ins(32'(8 * k + 4)), ins(32'(8 * k))}) begin errs++; $display("FAIL drain_instr[%0d] got=%h", k, out_instr); end
      step();
      checks++; if (count !== 4'(6 - 2 * k)) begin errs++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", k, count, 6 - 2 * k); end
      checks++; if (stall_F !== 1'b0) begin errs++; $display("FAIL drain_stall[%0d] got=%b exp=0", k, stall_F); end
    end
    drive(2'b00, 0, 0, 2'b00);
    checks++; if (out_valid !== 2'b00) begin errs++; $display("FAIL drain_empty got=%b exp=00", out_valid); end
  endtask
  task automatic test_partial();
    drive(2'b01, 32'h20, 32'h0, 2'b00);
    step();
    checks++; if (count !== 4'd1 || out_valid !== 2'b01) begin errs++; $display("FAIL partial_one got=%0d/%b exp=1/01", count, out_valid); end
    drive(2'b11, 32'h24, 32'h28, 2'b11);
    step();
    checks++; if (count !== 4'd2) begin errs++; $display("FAIL partial_count got=%0d exp=2", count); end
    checks++; if (out_pc !== {32'h28, 32'h24}) begin errs++; $display("FAIL partial_pc got=%h exp=%h", out_pc, {32'h28, 32'h24}); end
    drive(2'b00, 0, 0, 2'b11);
    step();
    checks++; if (count !== 4'd0) begin errs++; $display("FAIL partial_drain got=%0d exp=0", count); end
  endtask
  task automatic test_wrap();
    logic [1:0] iv [20] = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b00, 2'b11,
                            2'b01, 2'b11, 2'b10, 2'b11, 2'b11, 2'b01, 2'b00, 2'b11, 2'b01, 2'b11};
    logic [1:0] tk [20] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b11, 2'b10, 2'b00,
                            2'b11, 2'b01, 2'b11, 2'b00, 2'b10, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11};
    logic [31:0] q [$];
    logic [31:0] npc = 32'h200;
    for (int i = 0; i < 30; i++) begin
      int sz = q.size();
      logic [1:0] v = i < 20 ? iv[i] : 2'b00;
      logic [1:0] t = i < 20 ? tk[i] : 2'b11;
      logic [1:0] ev = sz >= 2 ? 2'b11 : sz == 1 ? 2'b01 : 2'b00;
      logic st = (8 - sz) < 2;
      int np, pp;
      if (i >= 20 && sz == 0) break;
      checks++; if (out_valid !== ev) begin errs++; $display("FAIL wrap_valid[%0d] got=%b exp=%b", i, out_valid, ev); end
      checks++; if (count !== 4'(sz)) begin errs++; $display("FAIL wrap_count[%0d] got=%0d exp=%0d", i, count, sz); end
      checks++; if (stall_F !== st) begin errs++; $display("FAIL wrap_stall[%0d] got=%b exp=%b", i, stall_F, st); end
      if (ev[0]) begin checks++; if (out_pc[31:0] !== q[0]) begin errs++; $display("FAIL wrap_pc0[%0d] got=%h exp=%h", i, out_pc[31:0], q[0]); end end
      if (ev[1]) begin checks++; if (out_pc[63:32] !== q[1]) begin errs++; $display("FAIL wrap_pc1[%0d] got=%h exp=%h", i, out_pc[63:32], q[1]); end end
      drive(v, npc, npc + 4, t);
      np = st ? 0 : v == 2'b11 ? 2 : v == 2'b01 ? 1 : 0;
      pp = ((t[0] && sz >= 1) ? 1 : 0) + ((t == 2'b11 && sz >= 2) ? 1 : 0);
      step();
      repeat (pp) void'(q.pop_front());
      if (np >= 1) q.push_back(npc);
      if (np == 2) q.push_back(npc + 4);
      npc += 32'(4 * np);
    end
    drive(2'b00, 0, 0, 2'b00);
    checks++; if (count !== 4'd0) begin errs++; $display("FAIL wrap_final_count got=%0d exp=0", count); end
  endtask
  task automatic test_flush();
    drive(2'b11, 32'h300, 32'h304, 2'b00);
    step();
    drive(2'b11, 32'h308, 32'h30C, 2'b00);
    step();
    drive(2'b01, 32'h310, 32'h0, 2'b00);
    step();
    checks++; if (count !== 4'd5) begin errs++; $display("FAIL flush_pre_count got=%0d exp=5", count); end
    drive(2'b11, 32'h318, 32'h31C, 2'b11);
    flush = 1;
    step();
    flush = 0;
    checks++; if (count !== 4'd0) begin errs++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 2'b00) begin errs++; $display("FAIL flush_valid got=%b exp=00", out_valid); end
    checks++; if (stall_F !== 1'b0) begin errs++; $display("FAIL flush_stall got=%b exp=0", stall_F); end
    drive(2'b11, 32'h100, 32'h104, 2'b00);
    step();
    drive(2'b00, 0, 0, 2'b00);
    checks++; if (out_pc !== {32'h104, 32'h100}) begin errs++; $display("FAIL flush_next_pc got=%h exp=%h", out_pc, {32'h104, 32'h100}); end
    checks++; if (count !== 4'd2 || out_valid !== 2'b11) begin errs++; $display("FAIL flush_next_count got=%0d/%b exp=2/11", count, out_valid); end
  endtask
  task automatic test_async_reset();
    #2 rst = 0;
    #1;
    checks++; if (count !== 4'd0 || out_valid !== 2'b00) begin errs++; $display("FAIL async_reset got=%0d/%b exp=0/00", count, out_valid); end
    checks++; if (out_pc !== 64'd0) begin errs++; $display("FAIL async_reset_pc got=%h exp=0", out_pc); end
    step();
    rst = 1;
    step();
    checks++; if (count !== 4'd0) begin errs++; $display("FAIL async_reset_after got=%0d exp=0", count); end
  endtask
  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_partial();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
